// File: rtl/f1_pkg.sv
// Shared types and default sizing for the F1 start-light sequencer.
//   state_t      : sequencer state encoding (IDLE, FILL, HOLD, OUT)
//   F1_N_LIGHTS  : default lamp count (legal 2..32)
//   F1_DELAY_W   : default width of the hold-delay load value
//   F1_RT_W      : default reaction-time counter width
package f1_pkg;

  localparam int unsigned F1_N_LIGHTS = 8;
  localparam int unsigned F1_DELAY_W  = 7;
  localparam int unsigned F1_RT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/f1_react_timer.sv
// Reaction timer for the F1 sequencer (built only with REACT_TIMER_EN).
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : global enable; low freezes everything, react_valid reads 0
//   state        : current sequencer state
//   done_set     : sequencer is entering OUT on this edge
//   start_ok     : sequencer is accepting a start on this edge
//   react        : driver reaction button
//   react_time   : latched clocks from the done cycle to the react press
//   react_valid  : one-cycle pulse when react_time is updated
//   jump_start   : sticky false-start flag, cleared by the next accepted start
module f1_react_timer
  import f1_pkg::*;
#(
  parameter int unsigned RT_W = F1_RT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  state_t          state,
  input  logic            done_set,
  input  logic            start_ok,
  input  logic            react,
  output logic [RT_W-1:0] react_time,
  output logic            react_valid,
  output logic            jump_start
);

  localparam logic [RT_W-1:0] CNT_MAX = '1;

  logic [RT_W-1:0] cnt;
  logic            armed;
  logic            take;

  // A press counts only once per completed sequence, and a start outranks it.
  assign take = (state == IDLE) && armed && react && !start_ok;

  // Counter reads 0 during the done cycle and k on the k-th clock after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      armed       <= 1'b0;
      react_time  <= '0;
      react_valid <= 1'b0;
      jump_start  <= 1'b0;
    end else if (en) begin
      react_valid <= 1'b0;
      if (done_set) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else if (start_ok) begin
        armed <= 1'b0;
      end else if ((state == OUT) || ((state == IDLE) && armed)) begin
        if (cnt != CNT_MAX) cnt <= cnt + RT_W'(1);
      end
      if (take) begin
        react_time  <= cnt;
        react_valid <= 1'b1;
        armed       <= 1'b0;
      end
      if (start_ok) begin
        jump_start <= 1'b0;
      end else if (react && ((state == FILL) || (state == HOLD))) begin
        jump_start <= 1'b1;
      end
    end else begin
      react_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fills a lamp bar one lamp per tick, holds it for
// delay_ticks+1 ticks, then extinguishes all lamps and pulses done.
// Optional build macro: REACT_TIMER_EN adds the reaction timer and its ports.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : global enable; low freezes all state, done reads 0
//   tick         : one-clock step strobe
//   start        : begin a sequence (IDLE only)
//   abort        : synchronous return to IDLE, outranks tick and start
//   delay_ticks  : hold length, sampled on the fill-complete tick
//   lights       : lamp bar, bit 0 first (registered)
//   cmd_seq      : in FILL (combinational decode)
//   cmd_delay    : in HOLD (combinational decode)
//   busy         : not IDLE (combinational decode)
//   done         : one-cycle pulse as lamps go out (registered)
//   react, react_time, react_valid, jump_start : REACT_TIMER_EN only
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int unsigned N_LIGHTS = F1_N_LIGHTS,
  parameter int unsigned DELAY_W  = F1_DELAY_W
`ifdef REACT_TIMER_EN
  ,
  parameter int unsigned RT_W     = F1_RT_W
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                tick,
  input  logic                start,
  input  logic                abort,
  input  logic [DELAY_W-1:0]  delay_ticks,
  output logic [N_LIGHTS-1:0] lights,
  output logic                cmd_seq,
  output logic                cmd_delay,
  output logic                busy,
  output logic                done
`ifdef REACT_TIMER_EN
  ,
  input  logic                react,
  output logic [RT_W-1:0]     react_time,
  output logic                react_valid,
  output logic                jump_start
`endif
);

  state_t              state;
  state_t              state_nxt;
  logic [N_LIGHTS-1:0] lights_nxt;
  logic [DELAY_W-1:0]  hold_cnt;
  logic [DELAY_W-1:0]  hold_nxt;
  logic                done_nxt;
  logic                fill_last;

  // The tick that lands on a bar whose second-to-last lamp is lit completes the fill.
  assign fill_last = lights[N_LIGHTS-2];

  // State and registered datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lights   <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      lights   <= lights_nxt;
      hold_cnt <= hold_nxt;
      done     <= done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (en) begin
      if (abort) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE:    if (start) state_nxt = FILL;
          FILL:    if (tick && fill_last) state_nxt = HOLD;
          HOLD:    if (tick && (hold_cnt == '0)) state_nxt = OUT;
          OUT:     state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // Output decode and next values for the registered outputs.
  always_comb begin
    cmd_seq    = (state == FILL);
    cmd_delay  = (state == HOLD);
    busy       = (state != IDLE);
    lights_nxt = lights;
    hold_nxt   = hold_cnt;
    done_nxt   = 1'b0;
    if (en) begin
      if (abort) begin
        lights_nxt = '0;
        hold_nxt   = '0;
      end else begin
        case (state)
          FILL: begin
            if (tick) begin
              lights_nxt = {lights[N_LIGHTS-2:0], 1'b1};
              if (fill_last) hold_nxt = delay_ticks;
            end
          end
          HOLD: begin
            if (tick) begin
              if (hold_cnt == '0) begin
                lights_nxt = '0;
                done_nxt   = 1'b1;
              end else begin
                hold_nxt = hold_cnt - DELAY_W'(1);
              end
            end
          end
          default: lights_nxt = '0;
        endcase
      end
    end
  end

`ifdef REACT_TIMER_EN
  logic start_ok;

  assign start_ok = en && (state == IDLE) && start && !abort;

  f1_react_timer #(
    .RT_W(RT_W)
  ) u_react_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .state       (state),
    .done_set    (done_nxt),
    .start_ok    (start_ok),
    .react       (react),
    .react_time  (react_time),
    .react_valid (react_valid),
    .jump_start  (jump_start)
  );
`endif

endmodule

// File: tb/tb_f1_light_seq.sv
// Directed self-checking bench for f1_light_seq (8-lamp and 4-lamp builds).
module tb_f1_light_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       tick;
  logic       start;
  logic       abort;
  logic [6:0] delay_ticks;
  logic [7:0] lights;
  logic       cmd_seq, cmd_delay, busy, done;
  logic [3:0] lights4;
  logic       cmd_seq4, cmd_delay4, busy4, done4;
`ifdef REACT_TIMER_EN
  logic        react;
  logic [15:0] react_time, react_time4;
  logic        react_valid, react_valid4;
  logic        jump_start, jump_start4;
`endif

  int vectors = 0;
  int errors  = 0;

  f1_light_seq #(.N_LIGHTS(8), .DELAY_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .start(start),
    .abort(abort), .delay_ticks(delay_ticks), .lights(lights),
    .cmd_seq(cmd_seq), .cmd_delay(cmd_delay), .busy(busy), .done(done)
`ifdef REACT_TIMER_EN
    , .react(react), .react_time(react_time), .react_valid(react_valid),
    .jump_start(jump_start)
`endif
  );

  f1_light_seq #(.N_LIGHTS(4), .DELAY_W(7)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .start(start),
    .abort(abort), .delay_ticks(delay_ticks), .lights(lights4),
    .cmd_seq(cmd_seq4), .cmd_delay(cmd_delay4), .busy(busy4), .done(done4)
`ifdef REACT_TIMER_EN
    , .react(react), .react_time(react_time4), .react_valid(react_valid4),
    .jump_start(jump_start4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status nibble: {busy, cmd_seq, cmd_delay, done}
  function automatic logic [3:0] st8();
    return {busy, cmd_seq, cmd_delay, done};
  endfunction

  function automatic logic [3:0] st4();
    return {busy4, cmd_seq4, cmd_delay4, done4};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++; if (lights !== 8'h00) begin errors++; $display("FAIL reset_lights got %h exp %h", lights, 8'h00); end
    vectors++; if (st8() !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp %b", st8(), 4'b0000); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    vectors++; if (st8() !== 4'b0000) begin errors++; $display("FAIL post_reset_idle got %b exp %b", st8(), 4'b0000); end
  endtask

  task automatic test_fill();
    logic [8:0] e;
    delay_ticks = 7'd3;
    go();
    vectors++; if ({st8(), lights} !== {4'b1100, 8'h00}) begin errors++; $display("FAIL fill_entry got %h exp %h", {st8(), lights}, {4'b1100, 8'h00}); end
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      e = (9'd1 << (i + 1)) - 9'd1;
      vectors++; if (lights !== e[7:0]) begin errors++; $display("FAIL fill_step%0d got %h exp %h", i, lights, e[7:0]); end
      vectors++; if (st8() !== ((i < 7) ? 4'b1100 : 4'b1010)) begin errors++; $display("FAIL fill_status%0d got %b exp %b", i, st8(), ((i < 7) ? 4'b1100 : 4'b1010)); end
    end
  endtask

  task automatic test_hold();
    cyc();
    vectors++; if ({st8(), lights} !== {4'b1010, 8'hFF}) begin errors++; $display("FAIL hold_idle_cycle got %h exp %h", {st8(), lights}, {4'b1010, 8'hFF}); end
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (i < 3) begin
        vectors++; if ({st8(), lights} !== {4'b1010, 8'hFF}) begin errors++; $display("FAIL hold_tick%0d got %h exp %h", i, {st8(), lights}, {4'b1010, 8'hFF}); end
      end else begin
        vectors++; if ({st8(), lights} !== {4'b1001, 8'h00}) begin errors++; $display("FAIL hold_done got %h exp %h", {st8(), lights}, {4'b1001, 8'h00}); end
      end
    end
    cyc();
    vectors++; if ({st8(), lights} !== {4'b0000, 8'h00}) begin errors++; $display("FAIL hold_after_done got %h exp %h", {st8(), lights}, {4'b0000, 8'h00}); end
    cyc();
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL done_single got %b exp %b", done, 1'b0); end
  endtask

  task automatic test_zero_delay();
    delay_ticks = 7'd0;
    go();
    ticks(8);
    vectors++; if ({st8(), lights} !== {4'b1010, 8'hFF}) begin errors++; $display("FAIL zd_full got %h exp %h", {st8(), lights}, {4'b1010, 8'hFF}); end
    ticks(1);
    vectors++; if ({st8(), lights} !== {4'b1001, 8'h00}) begin errors++; $display("FAIL zd_out got %h exp %h", {st8(), lights}, {4'b1001, 8'h00}); end
    cyc();
    vectors++; if (st8() !== 4'b0000) begin errors++; $display("FAIL zd_idle got %b exp %b", st8(), 4'b0000); end
  endtask

  task automatic test_start_with_tick();
    start = 1'b1;
    tick  = 1'b1;
    cyc();
    start = 1'b0;
    tick  = 1'b0;
    vectors++; if ({st8(), lights} !== {4'b1100, 8'h00}) begin errors++; $display("FAIL st_tick_entry got %h exp %h", {st8(), lights}, {4'b1100, 8'h00}); end
    ticks(1);
    vectors++; if (lights !== 8'h01) begin errors++; $display("FAIL st_tick_first got %h exp %h", lights, 8'h01); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    vectors++; if ({st8(), lights} !== {4'b0000, 8'h00}) begin errors++; $display("FAIL abort_fill got %h exp %h", {st8(), lights}, {4'b0000, 8'h00}); end
  endtask

  task automatic test_start_ignored();
    go();
    ticks(3);
    go();
    vectors++; if ({st8(), lights} !== {4'b1100, 8'h07}) begin errors++; $display("FAIL restart_ign got %h exp %h", {st8(), lights}, {4'b1100, 8'h07}); end
    ticks(4);
    vectors++; if ({st8(), lights} !== {4'b1100, 8'h7F}) begin errors++; $display("FAIL restart_7f got %h exp %h", {st8(), lights}, {4'b1100, 8'h7F}); end
    ticks(1);
    vectors++; if ({st8(), lights} !== {4'b1010, 8'hFF}) begin errors++; $display("FAIL restart_full got %h exp %h", {st8(), lights}, {4'b1010, 8'hFF}); end
  endtask

  task automatic test_abort();
    // Hold counter is 0 here, so a lone tick would end the sequence with done.
    abort = 1'b1;
    tick  = 1'b1;
    cyc();
    abort = 1'b0;
    tick  = 1'b0;
    vectors++; if ({st8(), lights} !== {4'b0000, 8'h00}) begin errors++; $display("FAIL abort_hold got %h exp %h", {st8(), lights}, {4'b0000, 8'h00}); end
    cyc();
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp %b", done, 1'b0); end
    abort = 1'b1;
    start = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    vectors++; if (st8() !== 4'b0000) begin errors++; $display("FAIL abort_beats_start got %b exp %b", st8(), 4'b0000); end
  endtask

  task automatic test_enable();
    delay_ticks = 7'd2;
    go();
    ticks(3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      cyc();
      vectors++; if ({st8(), lights} !== {4'b1100, 8'h07}) begin errors++; $display("FAIL en_freeze%0d got %h exp %h", i, {st8(), lights}, {4'b1100, 8'h07}); end
    end
    tick = 1'b0;
    en   = 1'b1;
    ticks(4);
    vectors++; if (lights !== 8'h7F) begin errors++; $display("FAIL en_resume got %h exp %h", lights, 8'h7F); end
    ticks(1);
    vectors++; if ({st8(), lights} !== {4'b1010, 8'hFF}) begin errors++; $display("FAIL en_full got %h exp %h", {st8(), lights}, {4'b1010, 8'hFF}); end
    en = 1'b0;
    ticks(3);
    en = 1'b1;
    ticks(2);
    vectors++; if ({st8(), lights} !== {4'b1010, 8'hFF}) begin errors++; $display("FAIL en_hold_frozen got %h exp %h", {st8(), lights}, {4'b1010, 8'hFF}); end
    ticks(1);
    vectors++; if ({st8(), lights} !== {4'b1001, 8'h00}) begin errors++; $display("FAIL en_hold_done got %h exp %h", {st8(), lights}, {4'b1001, 8'h00}); end
    cyc();
  endtask

  task automatic test_reset_mid_hold();
    delay_ticks = 7'd5;
    go();
    ticks(9);
    vectors++; if ({st8(), lights} !== {4'b1010, 8'hFF}) begin errors++; $display("FAIL rst_pre got %h exp %h", {st8(), lights}, {4'b1010, 8'hFF}); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if ({st8(), lights} !== {4'b0000, 8'h00}) begin errors++; $display("FAIL rst_async got %h exp %h", {st8(), lights}, {4'b0000, 8'h00}); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    vectors++; if ({st8(), lights} !== {4'b0000, 8'h00}) begin errors++; $display("FAIL rst_release got %h exp %h", {st8(), lights}, {4'b0000, 8'h00}); end
  endtask

  task automatic test_n4();
    logic [4:0] e;
    delay_ticks = 7'd1;
    go();
    for (int i = 0; i < 4; i++) begin
      ticks(1);
      e = (5'd1 << (i + 1)) - 5'd1;
      vectors++; if (lights4 !== e[3:0]) begin errors++; $display("FAIL n4_step%0d got %h exp %h", i, lights4, e[3:0]); end
      vectors++; if (st4() !== ((i < 3) ? 4'b1100 : 4'b1010)) begin errors++; $display("FAIL n4_status%0d got %b exp %b", i, st4(), ((i < 3) ? 4'b1100 : 4'b1010)); end
    end
    ticks(1);
    vectors++; if ({st4(), lights4} !== {4'b1010, 4'hF}) begin errors++; $display("FAIL n4_hold got %h exp %h", {st4(), lights4}, {4'b1010, 4'hF}); end
    ticks(1);
    vectors++; if ({st4(), lights4} !== {4'b1001, 4'h0}) begin errors++; $display("FAIL n4_done got %h exp %h", {st4(), lights4}, {4'b1001, 4'h0}); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

`ifdef REACT_TIMER_EN
  task automatic test_react();
    delay_ticks = 7'd0;
    go();
    vectors++; if (jump_start !== 1'b0) begin errors++; $display("FAIL js_init got %b exp %b", jump_start, 1'b0); end
    ticks(2);
    react = 1'b1;
    cyc();
    react = 1'b0;
    vectors++; if ({jump_start, busy, lights} !== {2'b11, 8'h03}) begin errors++; $display("FAIL js_set got %h exp %h", {jump_start, busy, lights}, {2'b11, 8'h03}); end
    ticks(6);
    ticks(1);
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL rt_done got %b exp %b", done, 1'b1); end
    repeat (37) cyc();
    react = 1'b1;
    cyc();
    react = 1'b0;
    vectors++; if ({react_valid, react_time} !== {1'b1, 16'd37}) begin errors++; $display("FAIL rt_latch got %h exp %h", {react_valid, react_time}, {1'b1, 16'd37}); end
    cyc();
    vectors++; if ({react_valid, react_time} !== {1'b0, 16'd37}) begin errors++; $display("FAIL rt_pulse_once got %h exp %h", {react_valid, react_time}, {1'b0, 16'd37}); end
    react = 1'b1;
    cyc();
    react = 1'b0;
    vectors++; if ({react_valid, react_time} !== {1'b0, 16'd37}) begin errors++; $display("FAIL rt_second_ign got %h exp %h", {react_valid, react_time}, {1'b0, 16'd37}); end
    vectors++; if (jump_start !== 1'b1) begin errors++; $display("FAIL js_sticky got %b exp %b", jump_start, 1'b1); end
    go();
    vectors++; if (jump_start !== 1'b0) begin errors++; $display("FAIL js_clear got %b exp %b", jump_start, 1'b0); end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    en          = 1'b1;
    tick        = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    delay_ticks = 7'd0;
`ifdef REACT_TIMER_EN
    react       = 1'b0;
`endif
    test_reset();
    test_fill();
    test_hold();
    test_zero_delay();
    test_start_with_tick();
    test_start_ignored();
    test_abort();
    test_enable();
    test_reset_mid_hold();
    test_n4();
`ifdef REACT_TIMER_EN
    test_react();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
